// File: rtl/sine_sweep_ctrl_pkg.sv
// sine_ctrl_pkg: shared FSM encoding and default widths for the sine sweep controller
// and the sine-sum top level.
package sine_ctrl_pkg;
    localparam int SINE_DW      = 12;
    localparam int SINE_CNT_W   = 8;
    localparam int SINE_DWELL_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/sine_sweep_ctrl_dwell_timer.sv
// sine_dwell_timer: loadable down-counter with a zero flag; holds at zero.
module sine_dwell_timer
    import sine_ctrl_pkg::*;
#(
    parameter int W = SINE_DWELL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/sine_sweep_ctrl.sv
// sine_sweep_ctrl: steps two DDS phase increments through a staircase of tones, each held
// dwell+1 cycles. Define SINE_SWEEP_PINGPONG_EN to sweep back down to the start values.
module sine_sweep_ctrl
    import sine_ctrl_pkg::*;
#(
    parameter int DW      = SINE_DW,
    parameter int CNT_W   = SINE_CNT_W,
    parameter int DWELL_W = SINE_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DW-1:0]      cfg_start_a,
    input  logic [DW-1:0]      cfg_start_b,
    input  logic [DW-1:0]      cfg_step,
    input  logic               cfg_mirror,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [DW-1:0]      delta_a,
    output logic [DW-1:0]      delta_b,
    output logic               busy,
    output logic               done
);
    state_t             r_state, w_next;
    logic [DW-1:0]      r_delta_a, r_delta_b, r_step;
    logic               r_mirror, r_busy, r_done;
    logic [CNT_W-1:0]   r_count, r_scnt;
    logic [DWELL_W-1:0] r_dwell;
    logic               w_go, w_run, w_adv, w_zero, w_last, w_down, w_sub_b;

    assign w_go  = (r_state == IDLE) && start;
    assign w_run = (r_state == LOAD) || (r_state == DWELL) || (r_state == STEP);
    assign w_adv = w_run && !abort && w_zero && !w_last;

    // The dwell timer is loaded on the edge that shows a new tone, so a tone ends when it reads zero.
    sine_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_go || w_adv),
        .i_val  (w_go ? cfg_dwell : r_dwell),
        .i_dec  (w_run),
        .o_zero (w_zero)
    );

`ifdef SINE_SWEEP_PINGPONG_EN
    logic r_dir;

    assign w_down = r_dir || (r_scnt == '0);
    assign w_last = (r_scnt == '0) && (r_dir || r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_dir <= 1'b0;
        else if (w_go)
            r_dir <= 1'b0;
        else if (w_adv && r_scnt == '0)
            r_dir <= 1'b1;
    end
`else
    assign w_down = 1'b0;
    assign w_last = (r_scnt == '0);
`endif

    assign w_sub_b = r_mirror ^ w_down;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:              w_next = start ? LOAD : IDLE;
            LOAD, DWELL, STEP: w_next = abort ? IDLE : !w_zero ? DWELL : w_last ? DONE : STEP;
            default:           w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_delta_a <= '0;
            r_delta_b <= '0;
            r_step    <= '0;
            r_mirror  <= 1'b0;
            r_count   <= '0;
            r_dwell   <= '0;
            r_scnt    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == LOAD) || (w_next == DWELL) || (w_next == STEP);
            r_done  <= (w_next == DONE);
            if (w_go) begin
                r_delta_a <= cfg_start_a;
                r_delta_b <= cfg_start_b;
                r_step    <= cfg_step;
                r_mirror  <= cfg_mirror;
                r_count   <= cfg_count;
                r_dwell   <= cfg_dwell;
                r_scnt    <= cfg_count;
            end else if (w_adv) begin
                r_delta_a <= w_down ? r_delta_a - r_step : r_delta_a + r_step;
                r_delta_b <= w_sub_b ? r_delta_b - r_step : r_delta_b + r_step;
                r_scnt    <= (r_scnt == '0) ? r_count - CNT_W'(1) : r_scnt - CNT_W'(1);
            end
        end
    end

    assign delta_a = r_delta_a;
    assign delta_b = r_delta_b;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// tb_sine_sweep_ctrl: directed sweeps; expected tones (A, B, hold cycles) and end-of-sweep
// done flags are queued by the stimulus and checked by an independent monitor.
module tb_sine_sweep_ctrl;
    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
        logic [15:0] len;
    } tone_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, cfg_mirror;
    logic [11:0] cfg_start_a, cfg_start_b, cfg_step, delta_a, delta_b;
    logic [7:0]  cfg_count;
    logic [15:0] cfg_dwell;
    logic        busy, done;

    tone_t exp_q[$];
    bit    end_q[$];
    int    n_chk = 0;
    int    n_pass = 0;

    sine_sweep_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_start_a (cfg_start_a),
        .cfg_start_b (cfg_start_b),
        .cfg_step    (cfg_step),
        .cfg_mirror  (cfg_mirror),
        .cfg_count   (cfg_count),
        .cfg_dwell   (cfg_dwell),
        .delta_a     (delta_a),
        .delta_b     (delta_b),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tone(input logic [11:0] a, input logic [11:0] b, input logic [15:0] len);
        tone_t t;
        t.a = a;
        t.b = b;
        t.len = len;
        exp_q.push_back(t);
    endtask

    // Issue a one-cycle start; returns #1 into the LOAD cycle.
    task automatic go(input logic [11:0] sa, input logic [11:0] sb, input logic [11:0] st,
                      input logic mir, input logic [7:0] cnt, input logic [15:0] dw, input logic ab);
        @(posedge clk);
        #1;
        cfg_start_a = sa;
        cfg_start_b = sb;
        cfg_step = st;
        cfg_mirror = mir;
        cfg_count = cnt;
        cfg_dwell = dw;
        start = 1'b1;
        abort = ab;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 64'(n < 300), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: tracks each tone run while busy, compares it on change, and checks done at busy fall.
    initial begin
        tone_t cur, e;
        bit    open = 0;
        bit    prev_busy = 0;
        bit    ed;
        cur = '0;
        forever begin
            @(negedge clk);
            if (open && (!busy || delta_a != cur.a || delta_b != cur.b)) begin
                open = 0;
                if (exp_q.size() == 0)
                    check("tone_unexpected", 64'(cur), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    check("tone", 64'(cur), 64'(e));
                end
            end
            if (busy) begin
                if (!open) begin
                    cur.a = delta_a;
                    cur.b = delta_b;
                    cur.len = 16'd1;
                    open = 1;
                end else
                    cur.len = cur.len + 16'd1;
            end
            if (prev_busy && !busy) begin
                ed = (end_q.size() != 0) ? end_q.pop_front() : 1'b0;
                check("done_at_end", 64'(done), 64'(ed));
            end else if (done)
                check("stray_done", 64'(done), 64'(0));
            prev_busy = busy;
        end
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_start_a = '0;
        cfg_start_b = '0;
        cfg_step = '0;
        cfg_mirror = 1'b0;
        cfg_count = '0;
        cfg_dwell = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_delta_a", 64'(delta_a), 64'(0));
        check("reset_delta_b", 64'(delta_b), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic sweep with a start pulse mid-sweep carrying different config
        tone(12'h100, 12'h200, 5);
        tone(12'h110, 12'h210, 5);
        tone(12'h120, 12'h220, 5);
        tone(12'h130, 12'h230, 5);
        end_q.push_back(1);
        go(12'h100, 12'h200, 12'h010, 1'b0, 8'd3, 16'd4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cfg_start_a = 12'h555;
        cfg_start_b = 12'h0AA;
        cfg_step = 12'h0F0;
        cfg_count = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        check("hold_final_a", 64'(delta_a), 64'(12'h130));
        check("hold_final_b", 64'(delta_b), 64'(12'h230));

        // Mirror with wrap-around, dwell 0: one cycle per tone
        tone(12'hFF8, 12'h008, 1);
        tone(12'h000, 12'h000, 1);
        tone(12'h008, 12'hFF8, 1);
        end_q.push_back(1);
        go(12'hFF8, 12'h008, 12'h008, 1'b1, 8'd2, 16'd0, 1'b0);
        wait_idle();

        // Degenerate count=0 dwell=0, with abort in the start cycle (start wins)
        tone(12'h3A5, 12'h05A, 1);
        end_q.push_back(1);
        go(12'h3A5, 12'h05A, 12'h123, 1'b0, 8'd0, 16'd0, 1'b1);
        wait_idle();

        // Abort in the second DWELL cycle of tone 2
        tone(12'h100, 12'h200, 5);
        tone(12'h110, 12'h210, 3);
        end_q.push_back(0);
        go(12'h100, 12'h200, 12'h010, 1'b0, 8'd3, 16'd4, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_idle();
        check("abort_hold_a", 64'(delta_a), 64'(12'h110));
        check("abort_hold_b", 64'(delta_b), 64'(12'h210));

        // Reset asserted mid-dwell acts immediately
        tone(12'h100, 12'h200, 2);
        end_q.push_back(0);
        go(12'h100, 12'h200, 12'h010, 1'b0, 8'd3, 16'd4, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_a", 64'(delta_a), 64'(0));
        check("async_rst_b", 64'(delta_b), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef SINE_SWEEP_PINGPONG_EN
        tone(12'h100, 12'h200, 2);
        tone(12'h110, 12'h210, 2);
        tone(12'h120, 12'h220, 2);
        tone(12'h110, 12'h210, 2);
        tone(12'h100, 12'h200, 2);
        end_q.push_back(1);
        go(12'h100, 12'h200, 12'h010, 1'b0, 8'd2, 16'd1, 1'b0);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        check("tones_left", 64'(exp_q.size()), 64'(0));
        check("ends_left", 64'(end_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
